// File: rtl/serial_fa_accumulator.sv
// serial_fa_accumulator
// Bit-serial N-bit adder: one full-adder cell plus a registered carry,
// consuming one operand bit pair per clock, LSB first, with a start/done
// handshake. Optional macro SERIAL_FA_SUB_EN adds a subtract mode (sub
// input) and a signed-overflow flag (ovf output).
module serial_fa_accumulator #(
  parameter int N  = 4,
  parameter int CW = 6
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [N-1:0] a_in,
  input  logic [N-1:0] b_in,
  input  logic         cin,
`ifdef SERIAL_FA_SUB_EN
  input  logic         sub,
  output logic         ovf,
`endif
  output logic         busy,
  output logic         done,
  output logic [N-1:0] sum,
  output logic         cout,
  output logic         s_bit
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ADD  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [N-1:0]  a_sh;
  logic [N-1:0]  b_sh;
  logic [N-1:0]  sum_sh;
  logic [N-1:0]  sum_sh_nxt;
  logic          carry;
  logic [CW-1:0] cnt;

  logic          fa_x;
  logic          fa_y;
  logic          fa_z;
  logic          fa_s;
  logic          fa_c;

  logic [N-1:0]  b_load;
  logic          c_load;

  // The single full-adder cell fed by the operand LSBs and the stored carry
  assign fa_x  = a_sh[0];
  assign fa_y  = b_sh[0];
  assign fa_z  = carry;
  assign fa_s  = fa_x ^ fa_y ^ fa_z;
  assign fa_c  = (fa_x & fa_y) | (fa_x & fa_z) | (fa_y & fa_z);
  assign s_bit = fa_s;

  // Subtraction is a + ~b + 1, so the cell is reused unchanged
`ifdef SERIAL_FA_SUB_EN
  assign b_load = sub ? ~b_in : b_in;
  assign c_load = sub ? 1'b1 : cin;
`else
  assign b_load = b_in;
  assign c_load = cin;
`endif

  // New sum bits enter at the MSB so the LSB-first stream lands in place
  generate
    if (N == 1) begin : g_one_bit
      assign sum_sh_nxt = fa_s;
    end else begin : g_multi_bit
      assign sum_sh_nxt = {fa_s, sum_sh[N-1:1]};
    end
  endgenerate

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  // Control FSM, operand/sum shifters and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      a_sh   <= '0;
      b_sh   <= '0;
      sum_sh <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_FA_SUB_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_sh  <= a_in;
            b_sh  <= b_load;
            carry <= c_load;
            cnt   <= '0;
            state <= ADD;
          end
        end
        ADD: begin
          sum_sh <= sum_sh_nxt;
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          carry  <= fa_c;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            sum   <= sum_sh_nxt;
            cout  <= fa_c;
`ifdef SERIAL_FA_SUB_EN
            // carry into the MSB is the stored carry during the last bit
            ovf   <= fa_z ^ fa_c;
`endif
            state <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
